// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared stall-vector layout, stall patterns, FSM encodings
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX_MC    = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : hazard inputs, iterative-unit handshake and hold outputs
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic                id_reg1_read_i;
  logic                id_reg2_read_i;
  reg_addr_t           id_reg1_addr_i;
  reg_addr_t           id_reg2_addr_i;
  logic                ex_is_load_i;
  reg_addr_t           ex_wd_i;
  logic                ex_mc_req_i;
  logic                mc_ready_i;
  logic                flush_i;

  logic [STALL_W-1:0]  stall_o;
  logic                mc_start_o;
  logic                mc_cancel_o;
  logic                mc_ack_o;
  logic                flush_o;
  logic [CNT_W-1:0]    stall_cnt_o;
  logic                mc_timeout_o;

  modport slave (
    input  id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
    input  ex_is_load_i, ex_wd_i, ex_mc_req_i, mc_ready_i, flush_i,
    output stall_o, mc_start_o, mc_cancel_o, mc_ack_o, flush_o,
    output stall_cnt_o, mc_timeout_o
  );

  modport master (
    output id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
    output ex_is_load_i, ex_wd_i, ex_mc_req_i, mc_ready_i, flush_i,
    input  stall_o, mc_start_o, mc_cancel_o, mc_ack_o, flush_o,
    input  stall_cnt_o, mc_timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : load-use stall, multi-cycle op sequencing, flush and stall count
//             Optional watchdog abort enabled by PIPE_CTRL_TIMEOUT_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall;
  logic               mc_start, mc_cancel, mc_ack;
  logic               lu;
  logic               to_hit;
  logic               flush_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  if (MC_TIMEOUT < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_ctrl: MC_TIMEOUT and CNT_W must be positive");
  end

  // r0 is hard-wired zero, so a load targeting it never creates a hazard
  assign lu = bus.ex_is_load_i && (bus.ex_wd_i != '0) &&
              ((bus.id_reg1_read_i && (bus.id_reg1_addr_i == bus.ex_wd_i)) ||
               (bus.id_reg2_read_i && (bus.id_reg2_addr_i == bus.ex_wd_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= bus.flush_i;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall     = STALL_NONE;
    mc_start  = 1'b0;
    mc_cancel = 1'b0;
    mc_ack    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ex_mc_req_i) begin
          state_d  = ST_BUSY;
          mc_start = 1'b1;
          stall    = STALL_EX_MC;
        end else if (lu) begin
          stall = STALL_LOAD_USE;
        end
      end
      ST_BUSY: begin
        stall = STALL_EX_MC;
        if (bus.mc_ready_i) begin
          state_d = ST_DONE;
        end else if (to_hit) begin
          state_d   = ST_IDLE;
          mc_cancel = 1'b1;
        end
      end
      ST_DONE: begin
        mc_ack  = 1'b1;
        state_d = ST_IDLE;
        if (lu) stall = STALL_LOAD_USE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush discards whatever EX holds, including an op about to start
    if (bus.flush_i) begin
      state_d   = ST_IDLE;
      stall     = STALL_NONE;
      mc_start  = 1'b0;
      mc_ack    = 1'b0;
      mc_cancel = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && bus.ex_mc_req_i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall != STALL_NONE) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_flag_q;

  // to_cnt_q holds the number of BUSY cycles already elapsed
  assign to_hit = (state_q == ST_BUSY) && (to_cnt_q == TO_W'(MC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q <= ((state_q == ST_BUSY) && !to_hit) ? to_cnt_q + 1'b1 : '0;
      if (to_hit && !bus.mc_ready_i && !bus.flush_i) to_flag_q <= 1'b1;
    end
  end

  assign bus.mc_timeout_o = to_flag_q;
`else
  assign to_hit           = 1'b0;
  assign bus.mc_timeout_o = 1'b0;
`endif

  assign bus.stall_o     = stall;
  assign bus.mc_start_o  = mc_start;
  assign bus.mc_cancel_o = mc_cancel;
  assign bus.mc_ack_o    = mc_ack;
  assign bus.flush_o     = flush_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] S_0  = 6'b000000;
  localparam logic [5:0] S_LU = 6'b000111;
  localparam logic [5:0] S_MC = 6'b001111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) pif ();

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_run  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  bit          exp_flush = 1'b0;
  bit          exp_to = 1'b0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_run++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, no expected entry", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then registered ones after the edge
  task automatic cyc(input string tag, input logic [5:0] es, input bit st,
                     input bit ca, input bit ak);
    push({tag, ".stall"},  32'(es));
    push({tag, ".start"},  32'(st));
    push({tag, ".cancel"}, 32'(ca));
    push({tag, ".ack"},    32'(ak));
    #1;
    pop_chk(32'(pif.stall_o));
    pop_chk(32'(pif.mc_start_o));
    pop_chk(32'(pif.mc_cancel_o));
    pop_chk(32'(pif.mc_ack_o));
    if (rst) begin
      exp_cnt   = '0;
      exp_flush = 1'b0;
      exp_to    = 1'b0;
    end else begin
      if ((es != S_0) && (exp_cnt != 16'hFFFF)) exp_cnt++;
      exp_flush = pif.flush_i;
    end
    @(posedge clk);
    #1;
    push({tag, ".cnt"},     32'(exp_cnt));
    push({tag, ".flush_o"}, 32'(exp_flush));
    push({tag, ".timeout"}, 32'(exp_to));
    pop_chk(32'(pif.stall_cnt_o));
    pop_chk(32'(pif.flush_o));
    pop_chk(32'(pif.mc_timeout_o));
  endtask

  task automatic idle_inputs();
    pif.id_reg1_read_i = 1'b0;
    pif.id_reg2_read_i = 1'b0;
    pif.id_reg1_addr_i = '0;
    pif.id_reg2_addr_i = '0;
    pif.ex_is_load_i   = 1'b0;
    pif.ex_wd_i        = '0;
    pif.ex_mc_req_i    = 1'b0;
    pif.mc_ready_i     = 1'b0;
    pif.flush_i        = 1'b0;
  endtask

  task automatic load_use(input logic ld, input logic [4:0] wd, input logic r1,
                          input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    pif.ex_is_load_i   = ld;
    pif.ex_wd_i        = wd;
    pif.id_reg1_read_i = r1;
    pif.id_reg1_addr_i = a1;
    pif.id_reg2_read_i = r2;
    pif.id_reg2_addr_i = a2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    cyc("reset0", S_0, 0, 0, 0);
    cyc("reset1", S_0, 0, 0, 0);
    rst = 1'b0;

    // Load-use hazards
    load_use(1, 5'd5, 1, 5'd3, 1, 5'd5);
    cyc("lu_p2", S_LU, 0, 0, 0);
    load_use(0, 5'd0, 1, 5'd3, 1, 5'd5);
    cyc("lu_gone", S_0, 0, 0, 0);
    load_use(1, 5'd9, 1, 5'd9, 0, 5'd0);
    cyc("lu_p1", S_LU, 0, 0, 0);
    load_use(1, 5'd9, 0, 5'd9, 1, 5'd5);
    cyc("lu_noread", S_0, 0, 0, 0);
    load_use(1, 5'd0, 1, 5'd0, 1, 5'd0);
    cyc("lu_r0", S_0, 0, 0, 0);
    load_use(0, 5'd9, 1, 5'd9, 1, 5'd9);
    cyc("lu_notload", S_0, 0, 0, 0);
    idle_inputs();

    // Ready outside BUSY is ignored
    pif.mc_ready_i = 1'b1;
    cyc("rdy_idle", S_0, 0, 0, 0);
    pif.mc_ready_i = 1'b0;
    cyc("rdy_idle2", S_0, 0, 0, 0);

    // Multi-cycle op, ready 10 cycles after start, from a cleared counter
    rst = 1'b1;
    cyc("reset2", S_0, 0, 0, 0);
    rst = 1'b0;
    pif.ex_mc_req_i = 1'b1;
    cyc("mc_start", S_MC, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc("mc_busy", S_MC, 0, 0, 0);
    pif.mc_ready_i = 1'b1;
    cyc("mc_ready", S_MC, 0, 0, 0);
    pif.mc_ready_i = 1'b0;
    cyc("mc_done", S_0, 0, 0, 1);
    push("mc_cnt11", 32'd11);
    pop_chk(32'(pif.stall_cnt_o));
    pif.ex_mc_req_i = 1'b0;
    cyc("mc_idle", S_0, 0, 0, 0);

    // Flush on the 4th BUSY cycle
    pif.ex_mc_req_i = 1'b1;
    cyc("fl_start", S_MC, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("fl_busy", S_MC, 0, 0, 0);
    pif.flush_i = 1'b1;
    cyc("fl_cancel", S_0, 0, 1, 0);
    pif.flush_i     = 1'b0;
    pif.ex_mc_req_i = 1'b0;
    cyc("fl_after", S_0, 0, 0, 0);

    // Load-use together with a request: multi-cycle pattern wins
    pif.ex_mc_req_i = 1'b1;
    load_use(1, 5'd5, 0, 5'd0, 1, 5'd5);
    cyc("lu_mc", S_MC, 1, 0, 0);
    load_use(0, 5'd0, 0, 5'd0, 0, 5'd0);

    // Flush and ready together in BUSY: no DONE, no ack
    pif.flush_i    = 1'b1;
    pif.mc_ready_i = 1'b1;
    cyc("fl_rdy", S_0, 0, 1, 0);
    idle_inputs();
    cyc("fl_rdy_noack", S_0, 0, 0, 0);

    // Flush in IDLE with a start pending: start suppressed, cancel issued
    pif.ex_mc_req_i = 1'b1;
    pif.flush_i     = 1'b1;
    cyc("fl_idle_start", S_0, 0, 1, 0);
    idle_inputs();
    cyc("fl_idle_after", S_0, 0, 0, 0);

    // Load-use seen during the DONE cycle
    pif.ex_mc_req_i = 1'b1;
    cyc("dlu_start", S_MC, 1, 0, 0);
    pif.mc_ready_i = 1'b1;
    cyc("dlu_ready", S_MC, 0, 0, 0);
    pif.mc_ready_i = 1'b0;
    load_use(1, 5'd7, 1, 5'd7, 0, 5'd0);
    cyc("dlu_done", S_LU, 0, 0, 1);
    idle_inputs();
    cyc("dlu_idle", S_0, 0, 0, 0);

    // Reset in the middle of BUSY: no cancel pulse
    pif.ex_mc_req_i = 1'b1;
    cyc("rb_start", S_MC, 1, 0, 0);
    cyc("rb_busy", S_MC, 0, 0, 0);
    rst = 1'b1;
    cyc("rb_rst", S_MC, 0, 0, 0);
    rst = 1'b0;
    pif.ex_mc_req_i = 1'b0;
    cyc("rb_after", S_0, 0, 0, 0);

`ifdef PIPE_CTRL_TIMEOUT_EN
    // Watchdog abort on the 8th BUSY cycle, sticky flag until reset
    pif.ex_mc_req_i = 1'b1;
    cyc("to_start", S_MC, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc("to_busy", S_MC, 0, 0, 0);
    exp_to = 1'b1;
    cyc("to_cancel", S_MC, 0, 1, 0);
    pif.ex_mc_req_i = 1'b0;
    cyc("to_idle0", S_0, 0, 0, 0);
    cyc("to_idle1", S_0, 0, 0, 0);
    rst = 1'b1;
    cyc("to_rst", S_0, 0, 0, 0);
    rst = 1'b0;
    cyc("to_cleared", S_0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
